// File: rtl/fft_pkg.sv
// fft_pkg: shared types and helpers for the streaming FFT/IFFT engine.
// Build option: define BFLY_SAT_EN to make sat_trunc clamp out-of-range
// results; otherwise results wrap to their low bits.
package fft_pkg;

  localparam int DW_DEF = 13;
  localparam int WW_DEF = 13;

  // One complex sample at the default data width.
  typedef struct packed {
    logic signed [DW_DEF-1:0] re;
    logic signed [DW_DEF-1:0] im;
  } cplx_t;

  // Range-checks r against a signed dw-bit range and reports ovf.
  // With BFLY_SAT_EN the returned value is clamped to the range; without it
  // r is returned unchanged and the caller keeps its low dw bits (wrap).
  function automatic logic signed [31:0] sat_trunc(
    input  logic signed [31:0] r,
    input  int                 dw,
    output logic               ovf
  );
    logic signed [31:0] lo;
    logic signed [31:0] hi;
    lo  = -(32'sd1 <<< (dw - 1));
    hi  = (32'sd1 <<< (dw - 1)) - 32'sd1;
    ovf = (r < lo) || (r > hi);
`ifdef BFLY_SAT_EN
    if (r > hi) begin
      return hi;
    end else if (r < lo) begin
      return lo;
    end else begin
      return r;
    end
`else
    return r;
`endif
  endfunction

endpackage

// File: rtl/butterfly_pipe_if.sv
// butterfly_pipe_if: input/output valid-ready streams of the butterfly core.
// slave = the butterfly, master = the producer/consumer driving it.
interface butterfly_pipe_if
  import fft_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int WW = WW_DEF
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic                 scale;
  logic                 inv;
  logic signed [WW-1:0] w_re;
  logic signed [WW-1:0] w_im;
  logic signed [DW-1:0] x1_re;
  logic signed [DW-1:0] x1_im;
  logic signed [DW-1:0] x2_re;
  logic signed [DW-1:0] x2_im;

  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] y1_re;
  logic signed [DW-1:0] y1_im;
  logic signed [DW-1:0] y2_re;
  logic signed [DW-1:0] y2_im;
  logic                 ovf;

  modport slave (
    input  in_valid, scale, inv, w_re, w_im, x1_re, x1_im, x2_re, x2_im,
    input  out_ready,
    output in_ready, out_valid, y1_re, y1_im, y2_re, y2_im, ovf
  );

  modport master (
    output in_valid, scale, inv, w_re, w_im, x1_re, x1_im, x2_re, x2_im,
    output out_ready,
    input  in_ready, out_valid, y1_re, y1_im, y2_re, y2_im, ovf
  );

endinterface

// File: rtl/cmult.sv
// cmult: first two butterfly stages. S1 captures the sample and the
// (optionally conjugated) twiddle, S2 forms the four partial products of
// w*x2 and rescales them by 2^-(WW-1). x1 and the scale flag ride along.
module cmult
  import fft_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int WW = WW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic                 scale,
  input  logic                 inv,
  input  logic signed [WW-1:0] w_re,
  input  logic signed [WW-1:0] w_im,
  input  logic signed [DW-1:0] x1_re,
  input  logic signed [DW-1:0] x1_im,
  input  logic signed [DW-1:0] x2_re,
  input  logic signed [DW-1:0] x2_im,
  output logic                 valid_s2,
  output logic                 scale_s2,
  output logic signed [DW-1:0] x1_re_s2,
  output logic signed [DW-1:0] x1_im_s2,
  output logic signed [DW+1:0] a,
  output logic signed [DW+1:0] b,
  output logic signed [DW+1:0] c,
  output logic signed [DW+1:0] d
);

  // Full product width, and width kept after the 2^-(WW-1) rescale.
  localparam int PW = DW + WW + 1;
  localparam int RW = DW + 2;

  // One extra bit so that negating -2^(WW-1) does not wrap.
  logic signed [WW:0] w_im_ext;
  logic signed [WW:0] w_im_eff;

  assign w_im_ext = {w_im[WW-1], w_im};
  assign w_im_eff = inv ? -w_im_ext : w_im_ext;

  logic                 s1_valid_reg;
  logic                 s1_scale_reg;
  logic signed [WW:0]   s1_w_re_reg;
  logic signed [WW:0]   s1_w_im_reg;
  logic signed [DW-1:0] s1_x1_re_reg;
  logic signed [DW-1:0] s1_x1_im_reg;
  logic signed [DW-1:0] s1_x2_re_reg;
  logic signed [DW-1:0] s1_x2_im_reg;

  // S1: capture the sample and the effective twiddle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_scale_reg <= 1'b0;
      s1_w_re_reg  <= '0;
      s1_w_im_reg  <= '0;
      s1_x1_re_reg <= '0;
      s1_x1_im_reg <= '0;
      s1_x2_re_reg <= '0;
      s1_x2_im_reg <= '0;
    end else if (ce) begin
      s1_valid_reg <= in_valid;
      s1_scale_reg <= scale;
      s1_w_re_reg  <= {w_re[WW-1], w_re};
      s1_w_im_reg  <= w_im_eff;
      s1_x1_re_reg <= x1_re;
      s1_x1_im_reg <= x1_im;
      s1_x2_re_reg <= x2_re;
      s1_x2_im_reg <= x2_im;
    end
  end

  // Operand pairing: a = wr*xr, b = wi*xi, c = wr*xi, d = wi*xr.
  logic signed [WW:0]   mul_w [4];
  logic signed [DW-1:0] mul_x [4];
  logic signed [RW-1:0] prod_next [4];
  logic signed [RW-1:0] prod_reg [4];

  assign mul_w[0] = s1_w_re_reg;
  assign mul_x[0] = s1_x2_re_reg;
  assign mul_w[1] = s1_w_im_reg;
  assign mul_x[1] = s1_x2_im_reg;
  assign mul_w[2] = s1_w_re_reg;
  assign mul_x[2] = s1_x2_im_reg;
  assign mul_w[3] = s1_w_im_reg;
  assign mul_x[3] = s1_x2_re_reg;

  // Arithmetic shift floors toward -inf; the result always fits DW+1 bits.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mul
      assign prod_next[gi] = RW'((PW'(mul_w[gi]) * PW'(mul_x[gi])) >>> (WW - 1));
    end
  endgenerate

  logic                 s2_valid_reg;
  logic                 s2_scale_reg;
  logic signed [DW-1:0] s2_x1_re_reg;
  logic signed [DW-1:0] s2_x1_im_reg;

  // S2: register the rescaled products and the pass-through fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      s2_scale_reg <= 1'b0;
      s2_x1_re_reg <= '0;
      s2_x1_im_reg <= '0;
      for (int i = 0; i < 4; i++) begin
        prod_reg[i] <= '0;
      end
    end else if (ce) begin
      s2_valid_reg <= s1_valid_reg;
      s2_scale_reg <= s1_scale_reg;
      s2_x1_re_reg <= s1_x1_re_reg;
      s2_x1_im_reg <= s1_x1_im_reg;
      for (int i = 0; i < 4; i++) begin
        prod_reg[i] <= prod_next[i];
      end
    end
  end

  assign valid_s2 = s2_valid_reg;
  assign scale_s2 = s2_scale_reg;
  assign x1_re_s2 = s2_x1_re_reg;
  assign x1_im_s2 = s2_x1_im_reg;
  assign a        = prod_reg[0];
  assign b        = prod_reg[1];
  assign c        = prod_reg[2];
  assign d        = prod_reg[3];

endmodule

// File: rtl/butterfly_pipe.sv
// butterfly_pipe: 3-stage radix-2 DIT butterfly y1 = x1 + w*x2,
// y2 = x1 - w*x2 with optional /2 scaling, conj(w) for IFFT and ovf flag.
// Build option: BFLY_SAT_EN clamps out-of-range outputs, otherwise they wrap.
// One global advance enable stalls the whole pipe under backpressure.
module butterfly_pipe
  import fft_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int WW = WW_DEF
) (
  input logic             clk,
  input logic             rst,
  butterfly_pipe_if.slave bus
);

  localparam int RW = DW + 2;

  logic out_valid_reg;
  logic ce;

  assign ce           = ~out_valid_reg | bus.out_ready;
  assign bus.in_ready = ce;

  logic                 valid_s2;
  logic                 scale_s2;
  logic signed [DW-1:0] x1_re_s2;
  logic signed [DW-1:0] x1_im_s2;
  logic signed [RW-1:0] a;
  logic signed [RW-1:0] b;
  logic signed [RW-1:0] c;
  logic signed [RW-1:0] d;

  cmult #(
    .DW(DW),
    .WW(WW)
  ) u_cmult (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .in_valid (bus.in_valid),
    .scale    (bus.scale),
    .inv      (bus.inv),
    .w_re     (bus.w_re),
    .w_im     (bus.w_im),
    .x1_re    (bus.x1_re),
    .x1_im    (bus.x1_im),
    .x2_re    (bus.x2_re),
    .x2_im    (bus.x2_im),
    .valid_s2 (valid_s2),
    .scale_s2 (scale_s2),
    .x1_re_s2 (x1_re_s2),
    .x1_im_s2 (x1_im_s2),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d)
  );

  // S3 arithmetic in DW+2 bits: wide enough for x1 +/- w*x2 at full scale.
  logic signed [RW-1:0] x1e_re;
  logic signed [RW-1:0] x1e_im;
  logic signed [RW-1:0] p_re;
  logic signed [RW-1:0] p_im;
  logic signed [RW-1:0] s [4];
  logic signed [RW-1:0] r [4];

  assign x1e_re = RW'(x1_re_s2);
  assign x1e_im = RW'(x1_im_s2);
  assign p_re   = a - b;
  assign p_im   = c + d;

  // Output order: y1_re, y1_im, y2_re, y2_im.
  assign s[0] = x1e_re + p_re;
  assign s[1] = x1e_im + p_im;
  assign s[2] = x1e_re - p_re;
  assign s[3] = x1e_im - p_im;

  // Scaling rounds half up: add one LSB, then floor-divide by two.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_scale
      assign r[gi] = scale_s2 ? ((s[gi] + RW'(1)) >>> 1) : s[gi];
    end
  endgenerate

  logic signed [DW-1:0] y_next [4];
  logic signed [DW-1:0] y_reg [4];
  logic                 ovf_next;
  logic                 ovf_one;
  logic                 ovf_reg;

  // Range check each result, clamp or wrap, and merge the overflow flags.
  always_comb begin
    ovf_next = 1'b0;
    ovf_one  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      y_next[i] = DW'(sat_trunc(32'(r[i]), DW, ovf_one));
      ovf_next  = ovf_next | ovf_one;
    end
  end

  // S3 register: outputs, ovf and out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      ovf_reg       <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        y_reg[i] <= '0;
      end
    end else if (ce) begin
      out_valid_reg <= valid_s2;
      ovf_reg       <= ovf_next;
      for (int i = 0; i < 4; i++) begin
        y_reg[i] <= y_next[i];
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.y1_re     = y_reg[0];
  assign bus.y1_im     = y_reg[1];
  assign bus.y2_re     = y_reg[2];
  assign bus.y2_im     = y_reg[3];

endmodule

// File: doc/butterfly_pipe.md
# butterfly_pipe

Pipelined, parametrised radix-2 DIT butterfly computing y1 = x1 + w·x2 and y2 = x1 − w·x2, with optional divide-by-2 scaling, forward/inverse twiddle mode, saturation and a per-sample overflow flag. It is the datapath core of the streaming FFT/IFFT engine. Input and output use valid/ready handshakes, so the block can sit between the sample RAM reader and the write-back path under backpressure. It accepts one butterfly per clock.

## Interface
- DW, 13: data width, signed s.(DW-1) fixed point, applies to x and y.
- WW, 13: twiddle width, signed s.(WW-1) fixed point.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept an input this cycle.
- scale  in  1  1 = divide results by 2 (round half up); travels with the sample.
- inv  in  1  1 = use conj(w) (IFFT); travels with the sample.
- w_re, w_im  in  WW each  twiddle factor.
- x1_re, x1_im, x2_re, x2_im  in  DW each  butterfly inputs.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the output.
- y1_re, y1_im, y2_re, y2_im  out  DW each  butterfly outputs.
- ovf  out  1  at least one of the four outputs exceeded DW range for this sample.

## Operation
- Transfer rules: an input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
- Global advance enable: ce = ~out_valid | out_ready. in_ready = ce, combinational from out_ready and out_valid.
- When ce = 1, every stage register and its valid bit advance. When ce = 0, everything holds, including internal bubbles.
- S1 (capture): register x1, x2, scale and inv. Register the twiddle as w_im_eff = inv ? −w_im : w_im, computed in WW+1 bits so that −(−2^(WW-1)) is exact.
- S2 (multiply): form four products of DW+WW+1 bits: a = w_re·x2_re, b = w_im_eff·x2_im, c = w_re·x2_im, d = w_im_eff·x2_re.
- S2 products: arithmetic-shift each product right by WW-1 (truncation toward −∞), then register.
- S3 (combine), computed in DW+2 bits with x1 sign-extended:
  - p_re = a − b, p_im = c + d.
  - s1 = x1 + p, s2 = x1 − p, per component.
  - If scale = 1: r = (s + 1) >>> 1. Otherwise r = s.
  - Range-check r against [−2^(DW-1), 2^(DW-1)−1]. ovf = OR of the four range checks.
  - Final y value per the Configuration section. Register y, ovf and out_valid.
- Reset values:
  - out_valid = 0, ovf = 0, all y = 0.
  - All internal valid bits = 0. Data registers = 0.
  - in_ready = 1 in the first cycle after reset.
- Reset mid-operation: in-flight samples are discarded. out_valid is 0 on the cycle after rst is sampled high, and no stale sample appears afterwards.
- Bubbles: in_valid = 0 while ce = 1 inserts a bubble, which propagates as valid = 0.
- Boundary: w = −1 (−2^(WW-1) + j0) and x = −2^(DW-1) are legal and must be handled without internal wrap.

## Timing
- Latency is 3 cycles: a sample accepted at edge n produces out_valid at edge n+3, provided ce stays high.
- Throughput is 1 sample/cycle while out_ready = 1.
- A stall of k cycles with out_ready = 0 delays all samples by exactly k cycles. No sample is lost or duplicated, and order is preserved.
- Simultaneous output transfer and input acceptance in the same cycle is required when full and out_ready = 1.

## Configuration
- BFLY_SAT_EN defined: out-of-range results clamp to 2^(DW-1)−1 or −2^(DW-1).
- BFLY_SAT_EN undefined: results wrap (the low DW bits of r are output).
- ovf is computed and output identically in both builds.

## Structure
- Package fft_pkg holds:
  - Defaults DW_DEF = 13 and WW_DEF = 13.
  - Function sat_trunc (range check plus clamp/wrap, guarded by BFLY_SAT_EN).
  - A complex-sample typedef, shared with the FFT address and control blocks.
- Sub-module cmult: stages S1–S2, the complex multiply with inv conjugation and the product shift, with ce and valid pass-through. butterfly_pipe instantiates it and implements S3.

## Test plan
- Scaled, w = −1 (w_re = −4096, w_im = 0), x1 = (1000, 0), x2 = (200, 0), scale = 1 → y1 = (400, 0), y2 = (600, 0), ovf = 0, out_valid 3 cycles after acceptance.
- Inverse mode, w = (0, −4096), x1 = 0, x2 = (0, 100), scale = 0:
  - inv = 0 → y1 = (100, 0), y2 = (−100, 0).
  - inv = 1 → y1 = (−100, 0), y2 = (100, 0).
- Overflow, w = (−4096, 0), x1 = x2 = (4000, 0), scale = 0 → y2_re = 4095 with BFLY_SAT_EN, −192 without; ovf = 1; y1 = (0, 0).
- Backpressure: stream 8 random samples back-to-back and hold out_ready low for 3 cycles mid-stream → in_ready low during the stall, all 8 outputs match the reference model in order.
- Reset mid-stream: assert rst for 1 cycle with 2 samples in flight → out_valid = 0 on the next cycle and stays 0 until new inputs propagate. The first post-reset output corresponds to the first post-reset input.
- Extremes: x1 = x2 = (−4096, −4096), w = (−4096, −4096), scale = 1, both inv values → outputs match a bit-exact model, with no internal wrap.
